// File: rtl/load_store_aligner.sv
// load_store_aligner: sequential load/store data path between execute stage and a word-wide memory port.
// Aligns store data/byte enables to memory lanes, extends load data per funct3, and
// (with LSA_MISALIGNED_EN defined) splits accesses crossing an XLEN/8 boundary into two beats.
// Without LSA_MISALIGNED_EN any misaligned access returns rsp_err=1 with no memory beat.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata   core request
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                      core response
//   mem_req_valid/mem_req_ready/mem_addr/mem_we/mem_be/mem_wdata memory beat request
//   mem_rsp_valid/mem_rdata                                    memory read data
module load_store_aligner #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
`ifdef LSA_MISALIGNED_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d, err_q, err_d, mis_q, mis_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d, b0_q, b0_d, b1_q, b1_d;

  logic [3:0]        req_size;
  logic              req_legal, req_mis;

  assign req_size  = 4'd1 << req_funct3[1:0];
  assign req_legal = req_we ? (!req_funct3[2] && (XLEN == 64 || req_funct3[1:0] != 2'b11))
                            : (req_funct3 != 3'b111 &&
                               (XLEN == 64 || (req_funct3 != 3'b011 && req_funct3 != 3'b110)));
  assign req_mis   = (5'(req_addr[OW-1:0]) + 5'(req_size)) > 5'(NB);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    mis_d   = mis_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        mis_d   = req_mis;
        err_d   = !req_legal || (req_mis && !SPLIT);
        b0_d    = '0;
        b1_d    = '0;
        state_d = err_d ? RESP : BEAT0;
      end
      BEAT0: if (mem_req_ready) state_d = !we_q ? WAIT0 : (mis_q ? BEAT1 : RESP);
      WAIT0: if (mem_rsp_valid) begin
        b0_d    = mem_rdata;
        state_d = mis_q ? BEAT1 : RESP;
      end
`ifdef LSA_MISALIGNED_EN
      BEAT1: if (mem_req_ready) state_d = we_q ? RESP : WAIT1;
      WAIT1: if (mem_rsp_valid) begin
        b1_d    = mem_rdata;
        state_d = RESP;
      end
`endif
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      b0_q    <= '0;
      b1_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
    end
  end

  // Everything below decodes only from state and the latched request.
  logic [OW-1:0]     off;
  logic [3:0]        size;
  logic [2*XLEN-1:0] wsh;
  logic [2*NB-1:0]   bsh;
  logic [ADDR_W-1:0] base;
  logic              beat, hi;

  assign off  = addr_q[OW-1:0];
  assign size = 4'd1 << f3_q[1:0];
  assign wsh  = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
  assign bsh  = (2*NB)'((16'd1 << size) - 16'd1) << off;
  assign base = addr_q & ~ADDR_W'(NB - 1);
  assign beat = state_q == BEAT0 || state_q == BEAT1;
  assign hi   = state_q == BEAT1;

  assign req_ready     = state_q == IDLE;
  assign rsp_valid     = state_q == RESP;
  assign rsp_err       = rsp_valid && err_q;
  assign mem_req_valid = beat;
  assign mem_we        = beat && we_q;
  assign mem_addr      = !beat ? '0 : hi ? base + ADDR_W'(NB) : base;
  assign mem_be        = !beat ? '0 : hi ? bsh[2*NB-1:NB] : bsh[NB-1:0];
  assign mem_wdata     = !(beat && we_q) ? '0 : hi ? wsh[2*XLEN-1:XLEN] : wsh[XLEN-1:0];

  // beat1 is cleared at accept, so an aligned access shifts in zeros from above.
  logic [XLEN-1:0] rsh, ext;
  logic [6:0]      nbits;
  logic            fill;

  assign rsh   = XLEN'({b1_q, b0_q} >> {off, 3'b000});
  assign nbits = {size, 3'b000};

  always_comb begin
    fill = !f3_q[2] && (size == 4'd1 ? rsh[7] : size == 4'd2 ? rsh[15] :
                        size == 4'd4 ? rsh[31] : rsh[XLEN-1]);
    for (int i = 0; i < XLEN; i++) ext[i] = (7'(i) < nbits) ? rsh[i] : fill;
  end

  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ext : '0;
endmodule

// File: tb/tb_load_store_aligner.sv
// tb_load_store_aligner: directed self-checking bench for load_store_aligner at XLEN=32.
module tb_load_store_aligner;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic        req_ready, rsp_valid, rsp_err, mem_req_valid, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int          total = 0, bad = 0;

  load_store_aligner #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    cyc();
    req_valid = 1'b0; req_wdata = 32'h5A5A_5A5A;
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
    check({tag, ".mreq"}, 32'(mem_req_valid), 32'd1);
    check({tag, ".maddr"}, mem_addr, a);
    check({tag, ".mwe"}, 32'(mem_we), 32'(we));
    if (we) begin
      check({tag, ".mbe"}, 32'(mem_be), 32'(be));
      check({tag, ".mwdata"}, mem_wdata, wd);
    end
    check({tag, ".early"}, 32'(rsp_valid), 32'd0);
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] d);
    check({tag, ".wait"}, 32'(mem_req_valid), 32'd0);
    mem_rdata = d; mem_rsp_valid = 1'b1;
    cyc();
    mem_rsp_valid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic resp(input string tag, input logic [31:0] d, input logic e);
    check({tag, ".rvalid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".rdata"}, rsp_rdata, d);
    check({tag, ".rerr"}, 32'(rsp_err), 32'(e));
    check({tag, ".nomem"}, 32'(mem_req_valid), 32'd0);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check({tag, ".idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    cyc(2);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", 32'(rsp_err), 32'd0);
    check("rst.mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_be", 32'(mem_be), 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    cyc();
    // aligned loads: beat at T1, data at T2, response at T3
    issue(1'b0, 3'b000, 32'h103, '0); beat("lb", 32'h100, 1'b0, '0, '0);
    rd("lb", 32'h80FF_1234); resp("lb", 32'hFFFF_FF80, 1'b0);
    issue(1'b0, 3'b101, 32'h102, '0); cyc(2); beat("lhu", 32'h100, 1'b0, '0, '0);
    rd("lhu", 32'h8001_0000); resp("lhu", 32'h0000_8001, 1'b0);
    issue(1'b0, 3'b100, 32'h101, '0); beat("lbu", 32'h100, 1'b0, '0, '0);
    rd("lbu", 32'h0000_9A00); resp("lbu", 32'h0000_009A, 1'b0);
    issue(1'b0, 3'b010, 32'h104, '0); beat("lw", 32'h104, 1'b0, '0, '0);
    rd("lw", 32'hCAFE_BABE); resp("lw", 32'hCAFE_BABE, 1'b0);
    // aligned stores: response the cycle after the handshake
    issue(1'b1, 3'b001, 32'h101, 32'h0000_ABCD); beat("sh", 32'h100, 1'b1, 4'b0110, 32'h00AB_CD00);
    resp("sh", 32'd0, 1'b0);
    issue(1'b1, 3'b000, 32'h103, 32'h1234_56EE); beat("sb", 32'h100, 1'b1, 4'b1000, 32'hEE00_0000);
    resp("sb", 32'd0, 1'b0);
    issue(1'b1, 3'b010, 32'h208, 32'h0102_0304); beat("sw", 32'h208, 1'b1, 4'b1111, 32'h0102_0304);
    resp("sw", 32'd0, 1'b0);
    // illegal encodings respond at T1 with no beat
    issue(1'b0, 3'b011, 32'h100, '0); resp("ld", 32'd0, 1'b1);
    issue(1'b0, 3'b111, 32'h100, '0); resp("l111", 32'd0, 1'b1);
    issue(1'b1, 3'b100, 32'h100, 32'hFFFF_FFFF); resp("s100", 32'd0, 1'b1);
`ifdef LSA_MISALIGNED_EN
    issue(1'b0, 3'b010, 32'h0FE, '0); beat("lwm0", 32'h0FC, 1'b0, '0, '0);
    rd("lwm0", 32'h3322_1111); beat("lwm1", 32'h100, 1'b0, '0, '0);
    rd("lwm1", 32'hAAAA_5544); resp("lwm", 32'h5544_3322, 1'b0);
    issue(1'b1, 3'b010, 32'h0FE, 32'hDDCC_BBAA); beat("swm0", 32'h0FC, 1'b1, 4'b1100, 32'hBBAA_0000);
    beat("swm1", 32'h100, 1'b1, 4'b0011, 32'h0000_DDCC); resp("swm", 32'd0, 1'b0);
    issue(1'b0, 3'b001, 32'hFFFF_FFFF, '0); beat("lhw0", 32'hFFFF_FFFC, 1'b0, '0, '0);
    rd("lhw0", 32'hAB00_0000); beat("lhw1", 32'h0000_0000, 1'b0, '0, '0);
    rd("lhw1", 32'h0000_00CD); resp("lhw", 32'hFFFF_CDAB, 1'b0);
`else
    issue(1'b0, 3'b010, 32'h0FE, '0); resp("lwm", 32'd0, 1'b1);
    issue(1'b1, 3'b010, 32'h0FE, 32'hDDCC_BBAA); resp("swm", 32'd0, 1'b1);
    issue(1'b0, 3'b001, 32'hFFFF_FFFF, '0); resp("lhw", 32'd0, 1'b1);
`endif
    // reset while waiting for read data; the late response must be dropped
    issue(1'b0, 3'b010, 32'h200, '0); beat("rw", 32'h200, 1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    check("rw.async_ready", 32'(req_ready), 32'd1);
    check("rw.async_rsp", 32'(rsp_valid), 32'd0);
    cyc();
    rst_n = 1'b1; mem_rdata = 32'h0000_0055; mem_rsp_valid = 1'b1;
    cyc();
    mem_rsp_valid = 1'b0;
    check("rw.drop_ready", 32'(req_ready), 32'd1);
    check("rw.drop_rsp", 32'(rsp_valid), 32'd0);
    check("rw.drop_mreq", 32'(mem_req_valid), 32'd0);
    // response held while rsp_ready is low; stray inputs ignored
    issue(1'b0, 3'b001, 32'h100, '0); beat("hold", 32'h100, 1'b0, '0, '0);
    rd("hold", 32'h1234_F00D);
    for (int i = 0; i < 5; i++) begin
      check("hold.rvalid", 32'(rsp_valid), 32'd1);
      check("hold.rdata", rsp_rdata, 32'hFFFF_F00D);
      req_valid = 1'b1; req_addr = 32'h300 + 32'(i); mem_rsp_valid = 1'b1; mem_rdata = 32'h0BAD_0000 + 32'(i);
      cyc();
    end
    req_valid = 1'b0; mem_rsp_valid = 1'b0;
    resp("hold", 32'hFFFF_F00D, 1'b0);
    issue(1'b0, 3'b000, 32'h100, '0); beat("b2b", 32'h100, 1'b0, '0, '0);
    rd("b2b", 32'h0000_007F); resp("b2b", 32'h0000_007F, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
